sqrt_req_arbiter: RTL and testbench
===================================

// Module: sqrt_req_arbiter
// PURPOSE
//  Shares one multi-cycle fixed-point square-root unit between NUM_REQ FPU requesters (lanes/warps).
//  Round-robin selects one request, pulses the unit's start, waits for its result pulse,
//  and holds the result in a one-entry response register until downstream accepts it.
//  Adds a watchdog so a lost result cannot hang the FPU pipe. One operation in flight at a time.
// PARAMETERS
//  NUM_REQ   4   number of requesters (>=2)
//  WIDTH     28  radicand/root/remainder width, matches the sqrt unit
//  FBITS     24  fractional bits, matches the sqrt unit
//  TAG_W     8   opaque per-request tag width, returned unchanged
//  TIMEOUT   64  max cycles from start pulse to unit valid before error response
// PORTS
//  clk        in   1              clock
//  reset      in   1              synchronous active-high reset
//  req_valid  in   NUM_REQ        per-requester request valid
//  req_ready  out  NUM_REQ        one-hot accept; at most one bit high per cycle
//  req_rad    in   NUM_REQ*WIDTH  packed radicands, requester i at [i*WIDTH +: WIDTH]
//  req_tag    in   NUM_REQ*TAG_W  packed tags, same packing
//  sqrt_start out  1              one-cycle start pulse to sqrt unit
//  sqrt_rad   out  WIDTH          radicand to sqrt unit, stable from ISSUE until next accept
//  sqrt_busy  in   1              sqrt unit busy
//  sqrt_valid in   1              sqrt unit result pulse
//  sqrt_root  in   WIDTH          sqrt unit root
//  sqrt_rem   in   WIDTH          sqrt unit remainder
//  rsp_valid  out  1              response valid
//  rsp_ready  in   1              downstream accepts response
//  rsp_id     out  $clog2(NUM_REQ) index of originating requester
//  rsp_tag    out  TAG_W          tag of originating request
//  rsp_root   out  WIDTH          captured root (0 on error)
//  rsp_rem    out  WIDTH          captured remainder (0 on error)
//  rsp_err    out  1              1 = watchdog timeout, result invalid
// BEHAVIOUR
//  Reset: state IDLE; req_ready=0, sqrt_start=0, sqrt_rad=0, rsp_valid=0, rsp_id/tag/root/rem=0,
//   rsp_err=0, RR pointer=0, watchdog=0. Reset mid-operation abandons it; no response emitted.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> (IDLE | ISSUE).
//  IDLE: if any req_valid, grant = first valid index at or after RR pointer (wrapping); req_ready[grant]=1
//   combinationally that cycle; capture rad/tag/id; RR pointer <= grant+1 (mod NUM_REQ); go ISSUE.
//  ISSUE: if !sqrt_busy, sqrt_start=1 for exactly this cycle, clear watchdog, go WAIT; else stay
//   (never pulse start while unit busy; a start to a busy unit restarts it and loses the op).
//  WAIT: watchdog increments each cycle. sqrt_valid=1 -> capture root/rem, rsp_err=0, go RESP.
//   Watchdog reaches TIMEOUT with no sqrt_valid -> root/rem=0, rsp_err=1, go RESP.
//  RESP: rsp_valid=1, all rsp_* stable until rsp_ready. On rsp_valid&rsp_ready: rsp_valid drops
//   next cycle; same cycle, if any req_valid, arbitrate as IDLE (req_ready asserted) and go ISSUE,
//   else go IDLE. req_ready is 0 in ISSUE/WAIT and in RESP without rsp_ready.
//  sqrt_valid outside WAIT (e.g. late result after timeout) is ignored.
//  Latency: accept in cycle A, start at A+1, unit valid at A+ITER+2, rsp_valid at A+ITER+3,
//   ITER=(WIDTH+FBITS)/2 -> 29 cycles at defaults. Throughput: one op per ITER+3 cycles with rsp_ready=1.
//  Fairness: a continuously valid requester is granted within NUM_REQ grants.
//  req_valid may drop without handshake; requester must hold rad/tag stable while valid.
//  Watchdog counter width $clog2(TIMEOUT+1); saturates, never wraps.
// STRUCTURE
//  Shared package/include fpu_sqrt_pkg: FSM state encodings (IDLE/ISSUE/WAIT/RESP, 2 bits),
//   SQRT_ITER=(WIDTH+FBITS)>>1 localparam, default TIMEOUT.
//  Sub-module rr_arbiter_onehot #(N): req vector + pointer -> one-hot grant, grant index, any.
//  sqrt unit is instantiated by the parent, not inside this block.
// TESTING
//  Single req: req_valid=0001, rad=4.0 (0x4000000) -> rsp at +29 cycles, root=2.0 (0x2000000), rem=0, id=0, err=0.
//  All 4 valid continuously, rsp_ready=1 -> grants 0,1,2,3,0 in order; ids match tags; 8 ops in 8*29 cycles.
//  rsp_ready=0 for 10 cycles after rsp_valid -> rsp_* stable, req_ready=0, no sqrt_start pulse.
//  Unit model never asserts sqrt_valid -> rsp_err=1, root=rem=0 after TIMEOUT+4 cycles; next op waits for !sqrt_busy.
//  sqrt_busy held 5 cycles when entering ISSUE -> start delayed exactly until busy drops, one pulse only.
//  reset asserted in WAIT -> next cycle all outputs at reset values; late sqrt_valid ignored; next req served normally.

Source files
------------

// File: rtl/fpu_sqrt_pkg.sv
// rtl/fpu_sqrt_pkg.sv - shared encodings and constants for the fpu square-root request path
package fpu_sqrt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sqrt_state_e;

  localparam int DEF_WIDTH   = 28;
  localparam int DEF_FBITS   = 24;
  localparam int DEF_TIMEOUT = 64;

  // One result bit per unit iteration, so the unit needs (WIDTH+FBITS)/2 cycles.
  localparam int SQRT_ITER = (DEF_WIDTH + DEF_FBITS) >> 1;

  function automatic int sqrt_iter(input int width, input int fbits);
    return (width + fbits) >> 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_onehot.sv
// rtl/rr_arbiter_onehot.sv - round-robin pick: first set request at or after the pointer, wrapping
module rr_arbiter_onehot #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any
);

  always_comb begin : find_first
    int          idx;
    logic [PW-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      cand = PW'(idx);
      if (!any && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sqrt_req_arbiter.sv
// rtl/sqrt_req_arbiter.sv - shares one multi-cycle sqrt unit between NUM_REQ requesters
// with round-robin grant, one-entry response register and a start-to-result watchdog.
module sqrt_req_arbiter
  import fpu_sqrt_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int FBITS   = DEF_FBITS,
  parameter int TAG_W   = 8,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_rad,
  input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
  output logic                       sqrt_start,
  output logic [WIDTH-1:0]           sqrt_rad,
  input  logic                       sqrt_busy,
  input  logic                       sqrt_valid,
  input  logic [WIDTH-1:0]           sqrt_root,
  input  logic [WIDTH-1:0]           sqrt_rem,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [TAG_W-1:0]           rsp_tag,
  output logic [WIDTH-1:0]           rsp_root,
  output logic [WIDTH-1:0]           rsp_rem,
  output logic                       rsp_err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int WDW = $clog2(TIMEOUT + 1);

  if (FBITS >= WIDTH) begin : g_fbits_check
    $error("FBITS must be smaller than WIDTH");
  end

  sqrt_state_e          state, state_nxt;
  logic [IDW-1:0]       rr_ptr;
  logic [NUM_REQ-1:0]   arb_grant;
  logic [IDW-1:0]       arb_idx;
  logic                 arb_any;
  logic [WDW-1:0]       wdog;
  logic                 wdog_expired;
  logic                 accept;

  rr_arbiter_onehot #(.N(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  assign wdog_expired = (wdog == WDW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
      ST_ISSUE: if (!sqrt_busy) state_nxt = ST_WAIT;
      ST_WAIT:  if (sqrt_valid || wdog_expired) state_nxt = ST_RESP;
      ST_RESP:  if (rsp_ready) state_nxt = accept ? ST_ISSUE : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are gated by reset so nothing handshakes while an operation is being abandoned.
  always_comb begin
    accept     = 1'b0;
    sqrt_start = 1'b0;
    rsp_valid  = 1'b0;
    unique case (state)
      ST_IDLE:  accept = arb_any;
      ST_ISSUE: sqrt_start = !sqrt_busy;
      ST_WAIT:  ;
      ST_RESP: begin
        rsp_valid = 1'b1;
        accept    = rsp_ready && arb_any;
      end
      default:  ;
    endcase
    if (reset) begin
      accept     = 1'b0;
      sqrt_start = 1'b0;
      rsp_valid  = 1'b0;
    end
    req_ready = accept ? arb_grant : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr   <= '0;
      sqrt_rad <= '0;
      rsp_id   <= '0;
      rsp_tag  <= '0;
      rsp_root <= '0;
      rsp_rem  <= '0;
      rsp_err  <= 1'b0;
      wdog     <= '0;
    end else begin
      if (accept) begin
        sqrt_rad <= req_rad[int'(arb_idx)*WIDTH +: WIDTH];
        rsp_tag  <= req_tag[int'(arb_idx)*TAG_W +: TAG_W];
        rsp_id   <= arb_idx;
        rr_ptr   <= (arb_idx == IDW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
      end
      if (state == ST_ISSUE && !sqrt_busy) begin
        wdog <= '0;
      end else if (state == ST_WAIT && !wdog_expired) begin
        wdog <= wdog + 1'b1;
      end
      // A result pulse in the same cycle the watchdog expires still wins.
      if (state == ST_WAIT) begin
        if (sqrt_valid) begin
          rsp_root <= sqrt_root;
          rsp_rem  <= sqrt_rem;
          rsp_err  <= 1'b0;
        end else if (wdog_expired) begin
          rsp_root <= '0;
          rsp_rem  <= '0;
          rsp_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sqrt_req_arbiter.sv
// tb/tb_sqrt_req_arbiter.sv - scoreboard bench for sqrt_req_arbiter with a behavioural sqrt unit
module tb_sqrt_req_arbiter;
  import fpu_sqrt_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 28;
  localparam int FBITS   = 24;
  localparam int TAG_W   = 8;
  localparam int TIMEOUT = 64;
  localparam int ITER    = SQRT_ITER;
  localparam int LAT     = ITER + 3;
  localparam int HANG    = 80;

  logic                       clk = 1'b0;
  logic                       reset;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*WIDTH-1:0]   req_rad;
  logic [NUM_REQ*TAG_W-1:0]   req_tag;
  logic                       sqrt_start;
  logic [WIDTH-1:0]           sqrt_rad;
  logic                       sqrt_busy;
  logic                       sqrt_valid;
  logic [WIDTH-1:0]           sqrt_root;
  logic [WIDTH-1:0]           sqrt_rem;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [1:0]                 rsp_id;
  logic [TAG_W-1:0]           rsp_tag;
  logic [WIDTH-1:0]           rsp_root;
  logic [WIDTH-1:0]           rsp_rem;
  logic                       rsp_err;

  always #5 clk = ~clk;

  sqrt_req_arbiter #(
    .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .FBITS(FBITS), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rad(req_rad), .req_tag(req_tag),
    .sqrt_start(sqrt_start), .sqrt_rad(sqrt_rad), .sqrt_busy(sqrt_busy),
    .sqrt_valid(sqrt_valid), .sqrt_root(sqrt_root), .sqrt_rem(sqrt_rem),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
    .rsp_root(rsp_root), .rsp_rem(rsp_rem), .rsp_err(rsp_err)
  );

  // Behavioural sqrt unit: result pulse ITER+1 cycles after start, or a late pulse in hang mode.
  logic             u_busy = 1'b0;
  logic             u_valid = 1'b0;
  int               u_cnt = 0;
  logic [WIDTH-1:0] u_rad = '0;
  logic [WIDTH-1:0] u_root = '0;
  logic [WIDTH-1:0] u_rem = '0;
  logic             busy_force = 1'b0;
  logic             hang_mode = 1'b0;

  assign sqrt_busy  = u_busy | busy_force;
  assign sqrt_valid = u_valid;
  assign sqrt_root  = u_root;
  assign sqrt_rem   = u_rem;

  function automatic longint unsigned isqrt(input longint unsigned v);
    longint unsigned rv = v;
    longint unsigned res = 0;
    longint unsigned b = 64'h4000_0000_0000_0000;
    while (b > rv) b = b >> 2;
    while (b != 0) begin
      if (rv >= res + b) begin
        rv  = rv - (res + b);
        res = (res >> 1) + b;
      end else begin
        res = res >> 1;
      end
      b = b >> 2;
    end
    return res;
  endfunction

  always @(posedge clk) begin
    longint unsigned s, r;
    u_valid <= 1'b0;
    if (sqrt_start) begin
      u_busy <= 1'b1;
      u_cnt  <= hang_mode ? HANG : ITER;
      u_rad  <= sqrt_rad;
    end else if (u_busy) begin
      u_cnt <= u_cnt - 1;
      if (u_cnt == 1) begin
        s = longint'(u_rad) << FBITS;
        r = isqrt(s);
        u_busy  <= 1'b0;
        u_valid <= 1'b1;
        u_root  <= r[WIDTH-1:0];
        u_rem   <= WIDTH'(s - r * r);
      end
    end
  end

  typedef struct {
    logic [1:0]       id;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] root;
    logic [WIDTH-1:0] rem;
    logic             err;
    int               lat_min;
    int               lat_max;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_starts = 0;
  int   last_start = -1;
  int   last_rsp = -1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [TAG_W-1:0] tag,
                          input logic [WIDTH-1:0] root, input logic [WIDTH-1:0] rem,
                          input logic err, input int lmin, input int lmax);
    exp_t e;
    e.id = id; e.tag = tag; e.root = root; e.rem = rem; e.err = err;
    e.lat_min = lmin; e.lat_max = lmax;
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Monitor: records accepts and start pulses, pops the scoreboard on every response handshake.
  initial forever begin
    exp_t e;
    int   a, lat;
    @(negedge clk);
    if (reset) begin
      acc_q.delete();
    end else begin
      if (req_ready != '0) begin
        check("req_ready_onehot", $countones(req_ready), 1);
        check("req_ready_subset_valid", req_ready & ~req_valid, 0);
        acc_q.push_back(cyc);
      end
      if (sqrt_start) begin
        check("start_while_busy", sqrt_busy, 0);
        n_starts++;
        last_start = cyc;
      end
      if (rsp_valid && rsp_ready) begin
        last_rsp = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: actual id=%0d tag=0x%0h required=no response", rsp_id, rsp_tag);
        end else begin
          e = exp_q.pop_front();
          a = (acc_q.size() > 0) ? acc_q.pop_front() : -1;
          check("rsp_id", rsp_id, e.id);
          check("rsp_tag", rsp_tag, e.tag);
          check("rsp_root", rsp_root, e.root);
          check("rsp_rem", rsp_rem, e.rem);
          check("rsp_err", rsp_err, e.err);
          if (e.lat_max > 0) begin
            lat = cyc - a;
            n_checks++;
            if (a < 0 || lat < e.lat_min || lat > e.lat_max) begin
              n_fail++;
              $display("FAIL rsp_latency: actual=%0d required=%0d..%0d", lat, e.lat_min, e.lat_max);
            end
          end
        end
      end
    end
  end

  task automatic load(input int lane, input logic [WIDTH-1:0] rad, input logic [TAG_W-1:0] tag);
    req_rad[lane*WIDTH +: WIDTH] = rad;
    req_tag[lane*TAG_W +: TAG_W] = tag;
  endtask

  task automatic drive_lanes(input logic [NUM_REQ-1:0] mask, output int first_acc);
    logic [NUM_REQ-1:0] pending, grabbed;
    int guard;
    pending   = mask;
    guard     = 0;
    first_acc = -1;
    req_valid = req_valid | mask;
    while (pending != '0 && guard < 1000) begin
      @(negedge clk);
      guard++;
      grabbed = req_ready & pending;
      if (grabbed != '0 && first_acc < 0) first_acc = cyc;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~grabbed;
      pending   = pending & ~grabbed;
    end
    if (pending != '0) begin
      check("accept_timeout", pending, 0);
      req_valid = req_valid & ~pending;
    end
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_req_ready"}, req_ready, 0);
    check({name, "_start"}, sqrt_start, 0);
    check({name, "_rsp_valid"}, rsp_valid, 0);
    check({name, "_sqrt_rad"}, sqrt_rad, 0);
    check({name, "_rsp_fields"}, {rsp_id, rsp_tag, rsp_root, rsp_rem, rsp_err}, 0);
  endtask

  logic [WIDTH-1:0] tv_rad[8], tv_root[8], tv_rem[8];

  initial begin
    int acc, starts0, guard;
    logic [127:0] snap;
    logic seen;

    tv_rad[0] = 28'h1000000; tv_root[0] = 28'h1000000; tv_rem[0] = 28'h0;
    tv_rad[1] = 28'h6400000; tv_root[1] = 28'h2800000; tv_rem[1] = 28'h0;
    tv_rad[2] = 28'h0000001; tv_root[2] = 28'h0001000; tv_rem[2] = 28'h0;
    tv_rad[3] = 28'h0010000; tv_root[3] = 28'h0100000; tv_rem[3] = 28'h0;
    tv_rad[4] = 28'h0000000; tv_root[4] = 28'h0000000; tv_rem[4] = 28'h0;
    tv_rad[5] = 28'h4000000; tv_root[5] = 28'h2000000; tv_rem[5] = 28'h0;
    tv_rad[6] = 28'h0000002; tv_root[6] = 28'h00016A0; tv_rem[6] = 28'h0001C00;
    tv_rad[7] = 28'h9000000; tv_root[7] = 28'h3000000; tv_rem[7] = 28'h0;

    reset = 1'b1; req_valid = '0; req_rad = '0; req_tag = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_reset_outputs("reset");

    // Single requests on each lane in turn; pointer walks back to 0.
    push_exp(2'd0, 8'h10, 28'h2000000, 28'h0, 1'b0, LAT, LAT);
    load(0, 28'h4000000, 8'h10); drive_lanes(4'b0001, acc); wait_drain();
    push_exp(2'd1, 8'h11, 28'h3000000, 28'h0, 1'b0, LAT, LAT);
    load(1, 28'h9000000, 8'h11); drive_lanes(4'b0010, acc); wait_drain();
    push_exp(2'd2, 8'h12, 28'h00016A0, 28'h0001C00, 1'b0, LAT, LAT);
    load(2, 28'h0000002, 8'h12); drive_lanes(4'b0100, acc); wait_drain();
    push_exp(2'd3, 8'h13, 28'h0800000, 28'h0, 1'b0, LAT, LAT);
    load(3, 28'h0400000, 8'h13); drive_lanes(4'b1000, acc); wait_drain();

    // All four lanes valid back to back: grants 0,1,2,3,0,1,2,3 at one op per LAT cycles.
    for (int k = 0; k < 8; k++) push_exp(2'(k % 4), 8'hA0 + 8'(k), tv_root[k], tv_rem[k], 1'b0, LAT, LAT);
    for (int l = 0; l < 4; l++) load(l, tv_rad[l], 8'hA0 + 8'(l));
    drive_lanes(4'b1111, acc);
    for (int l = 0; l < 4; l++) load(l, tv_rad[l+4], 8'hA4 + 8'(l));
    drive_lanes(4'b1111, guard);
    wait_drain();
    check("throughput_8_ops", last_rsp - acc, 8 * LAT);

    // Response backpressure holds everything and blocks new grants.
    rsp_ready = 1'b0;
    push_exp(2'd1, 8'h21, 28'h1800000, 28'h0, 1'b0, 0, 0);
    push_exp(2'd2, 8'h22, 28'h0001000, 28'h0, 1'b0, LAT, LAT);
    load(1, 28'h2400000, 8'h21); drive_lanes(4'b0010, acc);
    guard = 0;
    do begin @(negedge clk); guard++; end while (!rsp_valid && guard < 100);
    check("bp_rsp_valid_seen", rsp_valid, 1);
    snap = {rsp_id, rsp_tag, rsp_root, rsp_rem, rsp_err};
    @(posedge clk); #1;
    load(2, 28'h0000001, 8'h22); req_valid[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_rsp_valid_held", rsp_valid, 1);
      check("bp_rsp_stable", {rsp_id, rsp_tag, rsp_root, rsp_rem, rsp_err}, snap);
      check("bp_req_ready_low", req_ready, 0);
      check("bp_no_start", sqrt_start, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_grant_on_release", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(negedge clk);
    check("bp_rsp_valid_drops", rsp_valid, 0);
    wait_drain();

    // Unit busy for 5 cycles on entry to ISSUE: a single start, exactly when busy drops.
    starts0 = n_starts;
    push_exp(2'd3, 8'h33, 28'h0001000, 28'h0, 1'b0, LAT + 5, LAT + 5);
    load(3, 28'h0000001, 8'h33);
    drive_lanes(4'b1000, acc);
    busy_force = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    busy_force = 1'b0;
    wait_drain();
    check("busy_start_count", n_starts - starts0, 1);
    check("busy_start_cycle", last_start - acc, 6);

    // Unit never answers: error response, then the next op waits for the unit to go idle.
    starts0 = n_starts;
    hang_mode = 1'b1;
    push_exp(2'd0, 8'h40, 28'h0, 28'h0, 1'b1, TIMEOUT + 2, TIMEOUT + 4);
    push_exp(2'd1, 8'h41, 28'h2000000, 28'h0, 1'b0, 0, 0);
    load(0, 28'h9000000, 8'h40);
    drive_lanes(4'b0001, acc);
    @(posedge clk); #1;
    hang_mode = 1'b0;
    load(1, 28'h4000000, 8'h41);
    drive_lanes(4'b0010, acc);
    wait_drain();
    check("timeout_start_count", n_starts - starts0, 2);

    // Reset while waiting on the unit abandons the op; the late result is ignored.
    load(2, 28'h9000000, 8'h50);
    drive_lanes(4'b0100, acc);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("no_rsp_after_reset", seen, 0);
    @(posedge clk); #1;
    push_exp(2'd1, 8'h61, 28'h0100000, 28'h0, 1'b0, LAT, LAT);
    push_exp(2'd3, 8'h63, 28'h2800000, 28'h0, 1'b0, LAT, LAT);
    load(1, 28'h0010000, 8'h61);
    load(3, 28'h6400000, 8'h63);
    drive_lanes(4'b1010, acc);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=simulation still running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
